// File: rtl/pwm_dac_pkg.sv
// Shared constants and types for the PWM DAC.
package pwm_dac_pkg;

    localparam int unsigned      PWM_W          = 8;
    localparam int unsigned      PWM_PERIOD     = 256;
    localparam logic [PWM_W-1:0] PWM_MIDSCALE   = 8'd127;
    localparam int unsigned      UNDERRUN_CNT_W = 16;

    typedef logic [PWM_W-1:0] pwm_word_t;

    // Last count value of a PWM period; a tick here is a period boundary.
    localparam pwm_word_t CNT_LAST = pwm_word_t'(PWM_PERIOD - 1);

endpackage

// File: rtl/pwm_prescaler.sv
// Divides the system clock into PWM counter ticks; tick is high every PRESCALE cycles.
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned     PS_W    = 16;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] r_count;

    // With PRESCALE=1 the count never leaves 0, so tick stays high.
    assign tick = (r_count == PS_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_dac.sv
// 8-bit PWM DAC with a one-entry sample buffer, loaded at each 256-tick period boundary.
// Optional saturating underrun counter enabled by defining PWM_DAC_UNDERRUN_CNT_EN.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underrun
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);

    logic      w_tick;
    logic      w_boundary;
    logic      w_xfer;
    logic      w_load;
    logic      w_starve;
    logic      w_hold_full_d;

    pwm_word_t r_cnt;
    pwm_word_t r_duty;
    pwm_word_t r_hold;
    logic      r_hold_full;
    logic      r_ready;
    logic      r_pwm;
    logic      r_period_start;
    logic      r_underrun;

    pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(w_tick)
    );

    // Ready mirrors hold_full, so a load and a transfer never coincide.
    always_comb begin
        w_boundary    = w_tick && (r_cnt == CNT_LAST);
        w_xfer        = sample_valid && r_ready;
        w_load        = w_boundary && r_hold_full;
        w_starve      = w_boundary && !r_hold_full;
        w_hold_full_d = r_hold_full;
        if (w_load) begin
            w_hold_full_d = 1'b0;
        end else if (w_xfer) begin
            w_hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt          <= '0;
            r_duty         <= PWM_MIDSCALE;
            r_hold         <= '0;
            r_hold_full    <= 1'b0;
            r_ready        <= 1'b1;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_xfer) begin
                r_hold <= sample_in;
            end
            if (w_load) begin
                r_duty <= r_hold;
            end
            r_hold_full    <= w_hold_full_d;
            r_ready        <= !w_hold_full_d;
            r_pwm          <= (r_cnt < r_duty);
            r_period_start <= w_boundary;
            r_underrun     <= w_starve;
        end
    end

    assign sample_ready = r_ready;
    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
    assign underrun     = r_underrun;

`ifdef PWM_DAC_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

    // Counts in step with the underrun pulse register; sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_underrun_cnt <= '0;
        end else if (w_starve && (r_underrun_cnt != '1)) begin
            r_underrun_cnt <= r_underrun_cnt + 1'b1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: per-period duty/underrun scoreboard plus directed scenarios.
module tb_pwm_dac;

    logic       clk           = 1'b0;
    logic       rst           = 1'b0;
    logic [7:0] sample_in     = '0;
    logic       sample_valid  = 1'b0;
    logic       sample_ready;
    logic       pwm_out;
    logic       period_start;
    logic       underrun;

    logic       rst4          = 1'b0;
    logic [7:0] sample_in4    = '0;
    logic       sample_valid4 = 1'b0;
    logic       sample_ready4;
    logic       pwm_out4;
    logic       period_start4;
    logic       underrun4;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
    logic [15:0] underrun_cnt4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // One entry per expected period boundary: underrun flag and high count of the new period.
    typedef struct {
        int high;
        bit unr;
    } exp_t;
    exp_t exp_q[$];

    int acc       = 0;
    int cur_high  = 127;
    bit cur_valid = 1'b0;

    always #5 clk = ~clk;

    pwm_dac #(
        .PRESCALE(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .underrun    (underrun)
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    pwm_dac #(
        .PRESCALE(4)
    ) dut4 (
        .clk         (clk),
        .rst         (rst4),
        .sample_in   (sample_in4),
        .sample_valid(sample_valid4),
        .sample_ready(sample_ready4),
        .pwm_out     (pwm_out4),
        .period_start(period_start4),
        .underrun    (underrun4)
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt4)
`endif
    );

    task automatic push(input int high, input bit unr);
        exp_t e;
        e.high = high;
        e.unr  = unr;
        exp_q.push_back(e);
    endtask

    // Runs at every negedge: accumulates high cycles and scores each period boundary.
    task automatic mon();
        exp_t e;
        if (!rst) begin
            acc       = 0;
            cur_high  = 127;
            cur_valid = 1'b1;
            return;
        end
        acc += int'(pwm_out);
        if (underrun === 1'b1) begin
            n_tests++;
            if (period_start !== 1'b1) begin
                n_fail++;
                $display("FAIL underrun_alone: period_start=%b required 1 with underrun", period_start);
            end
        end
        if (period_start === 1'b1) begin
            if (cur_valid) begin
                n_tests++;
                if (acc !== cur_high) begin
                    n_fail++;
                    $display("FAIL period_high: got %0d high cycles, required %0d", acc, cur_high);
                end
            end
            acc = 0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (underrun !== e.unr) begin
                    n_fail++;
                    $display("FAIL boundary_underrun: got %b, required %b", underrun, e.unr);
                end
                cur_high  = e.high;
                cur_valid = 1'b1;
            end else begin
                cur_valid = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Returns aligned to the negedge showing a period_start with no further expectations.
    task automatic drain();
        int guard = 0;
        while ((exp_q.size() > 0 || cur_valid) && guard < 3000) begin
            step();
            guard++;
        end
        n_tests++;
        if (guard >= 3000) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
    endtask

    task automatic send_in_period(input int off, input logic [7:0] v);
        steps(off);
        sample_valid = 1'b1;
        sample_in    = v;
        step();
        sample_valid = 1'b0;
        steps(255 - off);
        n_tests++;
        if (period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL send_boundary: period_start=%b required 1", period_start);
        end
    endtask

    task automatic test_reset();
        int k;
        rst          = 1'b0;
        sample_valid = 1'b0;
        exp_q.delete();
        steps(3);
        n_tests++;
        if (pwm_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_pwm: got %b required 0", pwm_out);
        end
        n_tests++;
        if (period_start !== 1'b0) begin
            n_fail++; $display("FAIL rst_period_start: got %b required 0", period_start);
        end
        n_tests++;
        if (underrun !== 1'b0) begin
            n_fail++; $display("FAIL rst_underrun: got %b required 0", underrun);
        end
        n_tests++;
        if (sample_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_ready: got %b required 1", sample_ready);
        end
        rst = 1'b1;
        push(127, 1'b1);
        push(127, 1'b1);
        k = 0;
        do begin
            step();
            k++;
        end while (period_start !== 1'b1 && k < 600);
        n_tests++;
        if (k !== 256) begin
            n_fail++; $display("FAIL first_boundary: got %0d cycles required 256", k);
        end
        drain();
    endtask

    task automatic test_single();
        push(200, 1'b0);
        push(200, 1'b1);
        steps(10);
        sample_valid = 1'b1;
        sample_in    = 8'd200;
        step();
        sample_valid = 1'b0;
        n_tests++;
        if (sample_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_ready_low: got %b required 0", sample_ready);
        end
        steps(244);
        n_tests++;
        if (sample_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_ready_held: got %b required 0", sample_ready);
        end
        step();
        n_tests++;
        if (period_start !== 1'b1 || sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_load: period_start=%b ready=%b required 1 1",
                     period_start, sample_ready);
        end
        drain();
    endtask

    task automatic test_extremes();
        push(0, 1'b0);
        push(255, 1'b0);
        push(255, 1'b1);
        send_in_period(10, 8'd0);
        send_in_period(10, 8'd255);
        drain();
    endtask

    task automatic test_back_to_back();
        int val = 50;
        int ntx = 0;
        bit xfer;
        for (int i = 0; i < 768; i++) begin
            sample_valid = 1'b1;
            sample_in    = 8'(val);
            xfer         = sample_ready;
            step();
            if (xfer) begin
                push(val, 1'b0);
                val++;
                ntx++;
            end
        end
        sample_valid = 1'b0;
        n_tests++;
        if (ntx !== 3) begin
            n_fail++; $display("FAIL b2b_transfers: got %0d required 3", ntx);
        end
        drain();
    endtask

    task automatic test_collision();
        push(52, 1'b1);
        push(77, 1'b0);
        push(77, 1'b1);
        steps(255);
        n_tests++;
        if (sample_ready !== 1'b1) begin
            n_fail++; $display("FAIL coll_ready_pre: got %b required 1", sample_ready);
        end
        sample_valid = 1'b1;
        sample_in    = 8'd77;
        step();
        sample_valid = 1'b0;
        n_tests++;
        if (period_start !== 1'b1 || underrun !== 1'b1 || sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_boundary: ps=%b unr=%b ready=%b required 1 1 0",
                     period_start, underrun, sample_ready);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        steps(10);
        sample_valid = 1'b1;
        sample_in    = 8'd99;
        step();
        sample_valid = 1'b0;
        steps(50);
        n_tests++;
        if (sample_ready !== 1'b0 || pwm_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: ready=%b pwm=%b required 0 1", sample_ready, pwm_out);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (sample_ready !== 1'b1 || pwm_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: ready=%b pwm=%b required 1 0", sample_ready, pwm_out);
        end
        exp_q.delete();
        steps(2);
        rst = 1'b1;
        push(127, 1'b1);
        drain();
    endtask

    task automatic test_prescale();
        int k;
        int highs;
        rst4 = 1'b0;
        steps(3);
        rst4 = 1'b1;
        for (int p = 0; p < 2; p++) begin
            k = 0;
            do begin
                step();
                k++;
            end while (period_start4 !== 1'b1 && k < 3000);
            n_tests++;
            if (k !== 1024) begin
                n_fail++; $display("FAIL ps4_period%0d: got %0d cycles required 1024", p, k);
            end
        end
        steps(499);
        n_tests++;
        if (pwm_out4 !== 1'b1) begin
            n_fail++; $display("FAIL ps4_pre_reset: pwm=%b required 1", pwm_out4);
        end
        rst4 = 1'b0;
        #1;
        n_tests++;
        if (pwm_out4 !== 1'b0 || period_start4 !== 1'b0 || underrun4 !== 1'b0 ||
            sample_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL ps4_reset: pwm=%b ps=%b unr=%b ready=%b required 0 0 0 1",
                     pwm_out4, period_start4, underrun4, sample_ready4);
        end
        steps(2);
        rst4  = 1'b1;
        highs = 0;
        for (int i = 0; i < 1024; i++) begin
            step();
            highs += int'(pwm_out4);
        end
        n_tests++;
        if (highs !== 508) begin
            n_fail++; $display("FAIL ps4_duty: got %0d high cycles required 508", highs);
        end
        n_tests++;
        if (period_start4 !== 1'b1) begin
            n_fail++; $display("FAIL ps4_boundary: period_start=%b required 1", period_start4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        test_prescale();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
